// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory with peripheral window.
// Offsets are byte offsets inside the 32-byte IO window.
package dmem_mmio_pkg;

  localparam logic [4:0] OFS_SW    = 5'h00;
  localparam logic [4:0] OFS_LED   = 5'h04;
  localparam logic [4:0] OFS_EDGE  = 5'h08;
  localparam logic [4:0] OFS_COUNT = 5'h0C;
  localparam logic [4:0] OFS_CMP   = 5'h10;
  localparam logic [4:0] OFS_CTRL  = 5'h14;
  localparam logic [4:0] OFS_IRQ   = 5'h18;
  localparam logic [4:0] OFS_RSVD  = 5'h1C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_TIE    = 2;
  localparam int CTRL_SIE    = 3;

  localparam int IRQ_TMR = 0;
  localparam int IRQ_SW  = 1;

  function automatic logic io_ro(input logic [4:0] ofs);
    return (ofs == OFS_SW) || (ofs == OFS_RSVD);
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare match and optional
// reload to zero; a CPU load of COUNT suppresses the match.
module mmio_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_reload,
  input  logic        i_cnt_we,
  input  logic        i_cmp_we,
  input  logic [31:0] i_wd,
  output logic        o_match,
  output logic [31:0] o_count,
  output logic [31:0] o_cmp
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        w_match;

  assign w_match = i_en & ~i_cnt_we
                 & (r_count == r_cmp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_cmp   <= '1;
    end else begin
      if (i_cmp_we)
        r_cmp <= i_wd;
      if (i_cnt_we)
        r_count <= i_wd;
      else if (w_match & i_reload)
        r_count <= '0;
      else if (i_en)
        r_count <= r_count + 32'd1;
    end
  end

  assign o_match = w_match;
  assign o_count = r_count;
  assign o_cmp   = r_cmp;

endmodule

// File: rtl/dmem_mmio.sv
// Word RAM with byte lanes plus a peripheral register window
// (switches, LEDs, timer, interrupt status); reads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          NUM_SW      = 10,
  parameter int          NUM_LED     = 10,
  parameter logic [31:0] IO_BASE     = 32'hC000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [31:0]        a,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds,
  output logic               irq,
  output logic               bad_wr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [NUM_LED-1:0] r_leds;
  logic [NUM_SW-1:0]  r_sw_meta;
  logic [NUM_SW-1:0]  r_sw_sync;
  logic [NUM_SW-1:0]  r_sw_edge;
  logic [3:0]         r_ctrl;
  logic               r_tstat;
  logic               r_irq;
  logic               r_bad;

  logic          w_ram;
  logic          w_io;
  logic [4:0]    w_ofs;
  logic [AW-1:0] w_idx;
  logic          w_wr_io;
  logic          w_bad;
  logic          w_match;
  logic [31:0]   w_count;
  logic [31:0]   w_cmp;

  assign w_ram = a < 32'(DEPTH_WORDS * 4);
  assign w_io  = a[31:5] == IO_BASE[31:5];
  assign w_ofs = {a[4:2], 2'b00};
  assign w_idx = a[AW+1:2];

  // Only full-word writes to writable registers land
  assign w_wr_io = we & w_io & (be == 4'hF)
                 & ~io_ro(w_ofs);
  assign w_bad   = we & ~w_ram & ~w_wr_io;

  mmio_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (r_ctrl[CTRL_EN]),
    .i_reload (r_ctrl[CTRL_RELOAD]),
    .i_cnt_we (w_wr_io & (w_ofs == OFS_COUNT)),
    .i_cmp_we (w_wr_io & (w_ofs == OFS_CMP)),
    .i_wd     (wd),
    .o_match  (w_match),
    .o_count  (w_count),
    .o_cmp    (w_cmp)
  );

  always_ff @(posedge clk) begin
    if (we & w_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          r_mem[w_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Hardware set beats software clear for both sticky sources
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_leds    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_edge <= '0;
      r_ctrl    <= '0;
      r_tstat   <= 1'b0;
      r_irq     <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      r_sw_meta <= switches;
      r_sw_sync <= r_sw_meta;
      if (w_wr_io & (w_ofs == OFS_LED))
        r_leds <= wd[NUM_LED-1:0];
      if (w_wr_io & (w_ofs == OFS_CTRL))
        r_ctrl <= wd[3:0];
      if (w_wr_io & (w_ofs == OFS_EDGE))
        r_sw_edge <= (r_sw_edge & ~wd[NUM_SW-1:0])
                   | (r_sw_meta & ~r_sw_sync);
      else
        r_sw_edge <= r_sw_edge
                   | (r_sw_meta & ~r_sw_sync);
      if (w_match)
        r_tstat <= 1'b1;
      else if (w_wr_io & (w_ofs == OFS_IRQ)
               & wd[IRQ_TMR])
        r_tstat <= 1'b0;
      r_irq <= (r_tstat & r_ctrl[CTRL_TIE])
             | ((|r_sw_edge) & r_ctrl[CTRL_SIE]);
      r_bad <= w_bad;
    end
  end

  always_comb begin
    rd = '0;
    if (w_ram) begin
      rd = r_mem[w_idx];
    end else if (w_io) begin
      case (w_ofs)
        OFS_SW:    rd = 32'(r_sw_sync);
        OFS_LED:   rd = 32'(r_leds);
        OFS_EDGE:  rd = 32'(r_sw_edge);
        OFS_COUNT: rd = w_count;
        OFS_CMP:   rd = w_cmp;
        OFS_CTRL:  rd = 32'(r_ctrl);
        OFS_IRQ: begin
          rd[IRQ_TMR] = r_tstat;
          rd[IRQ_SW]  = |r_sw_edge;
        end
        default:   rd = '0;
      endcase
    end
  end

  assign leds   = r_leds;
  assign irq    = r_irq;
  assign bad_wr = r_bad;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_dmem_mmio;

  localparam int          DW  = 64;
  localparam logic [31:0] IOB = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;
  logic        irq;
  logic        bad_wr;

  always #5 clk = ~clk;

  dmem_mmio #(
    .DEPTH_WORDS (DW),
    .NUM_SW      (10),
    .NUM_LED     (10),
    .IO_BASE     (IOB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (we),
    .be       (be),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .switches (switches),
    .leds     (leds),
    .irq      (irq),
    .bad_wr   (bad_wr)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Behavioural model
  logic [31:0] m_mem [DW];
  logic [3:0]  m_vld [DW];
  logic [9:0]  m_leds, m_s1, m_s2, m_edge, t_edge;
  logic [31:0] m_cnt, m_cmp, t_cnt, t_off;
  logic [3:0]  m_ctrl;
  logic        m_tstat, m_irq, m_bad;
  logic        t_io, t_ram, t_legal, t_match, t_irq;

  function automatic logic [31:0] bmask(input logic [3:0] v);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{v[i]}};
    return m;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] ad);
    if (ad < DW * 4) return m_mem[ad[7:2]];
    if (ad[31:5] != IOB[31:5]) return 32'h0;
    case (ad[4:2])
      3'd0: return 32'(m_s2);
      3'd1: return 32'(m_leds);
      3'd2: return 32'(m_edge);
      3'd3: return m_cnt;
      3'd4: return m_cmp;
      3'd5: return 32'(m_ctrl);
      3'd6: return {30'h0, m_edge != 0, m_tstat};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_msk(input logic [31:0] ad);
    if (ad < DW * 4) return bmask(m_vld[ad[7:2]]);
    return 32'hFFFF_FFFF;
  endfunction

  initial for (int i = 0; i < DW; i++) m_vld[i] = 4'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_leds = '0; m_s1 = '0; m_s2 = '0; m_edge = '0;
      m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0;
      m_tstat = 0; m_irq = 0; m_bad = 0;
    end else begin
      t_off   = a & 32'h1C;
      t_io    = a[31:5] == IOB[31:5];
      t_ram   = a < DW * 4;
      t_legal = we && t_io && be == 4'hF
                && t_off != 0 && t_off != 32'h1C;
      t_irq   = (m_tstat && m_ctrl[2])
                || (m_edge != 0 && m_ctrl[3]);
      t_match = 0;
      t_cnt   = m_cnt;
      if (t_legal && t_off == 32'h0C) t_cnt = wd;
      else if (m_ctrl[0]) begin
        t_match = m_cnt == m_cmp;
        t_cnt = (t_match && m_ctrl[1]) ? 0 : m_cnt + 1;
      end
      t_edge = m_edge;
      if (t_legal && t_off == 32'h08) t_edge &= ~wd[9:0];
      t_edge |= m_s1 & ~m_s2;
      if (t_legal && t_off == 32'h18 && wd[0]) m_tstat = 0;
      if (t_match) m_tstat = 1;
      if (t_legal && t_off == 32'h04) m_leds = wd[9:0];
      if (t_legal && t_off == 32'h10) m_cmp = wd;
      if (t_legal && t_off == 32'h14) m_ctrl = wd[3:0];
      if (we && t_ram)
        for (int i = 0; i < 4; i++)
          if (be[i]) begin
            m_mem[a[7:2]][8*i +: 8] = wd[8*i +: 8];
            m_vld[a[7:2]][i] = 1'b1;
          end
      m_bad  = we && !t_ram && !t_legal;
      m_irq  = t_irq;
      m_cnt  = t_cnt;
      m_edge = t_edge;
      m_s2   = m_s1;
      m_s1   = switches;
    end
  end

  logic [31:0] c_msk;
  always @(negedge clk) begin
    if (chk_en) begin
      c_msk = m_msk(a);
      check("rd", rd & c_msk, m_rd(a) & c_msk);
      check("leds", 32'(leds), 32'(m_leds));
      check("irq", 32'(irq), 32'(m_irq));
      check("bad_wr", 32'(bad_wr), 32'(m_bad));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] ad,
                    input logic [31:0] d,
                    input logic [3:0] b);
    a = ad; wd = d; be = b; we = 1'b1;
    cyc();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd_chk(input logic [31:0] ad,
                        input logic [31:0] exp,
                        input string nm);
    we = 1'b0; be = 4'h0; a = ad;
    #1;
    check(nm, rd, exp);
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc();
    reset_n = 1'b1;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd_chk(IOB + 32'h0C, 32'h0, "rst_count");
    rd_chk(IOB + 32'h10, 32'hFFFF_FFFF, "rst_cmp");
    cyc();

    // byte lanes
    wr(32'h10, 32'hAABB_CCDD, 4'hF);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    check("lane_bad", 32'(bad_wr), 32'h0);
    rd_chk(32'h10, 32'hAA22_CC44, "lanes");

    // switches
    wr(IOB + 32'h14, 32'h8, 4'hF);
    switches = 10'h005;
    cyc();
    rd_chk(IOB, 32'h0, "sw_n1");
    cyc();
    rd_chk(IOB, 32'h5, "sw_n2");
    rd_chk(IOB + 32'h08, 32'h5, "sw_edge");
    rd_chk(IOB + 32'h18, 32'h2, "sw_stat");
    cyc();
    check("sw_irq", 32'(irq), 32'h1);
    wr(IOB + 32'h08, 32'h1, 4'hF);
    rd_chk(IOB + 32'h08, 32'h4, "sw_w1c");
    check("sw_irq2", 32'(irq), 32'h1);
    switches = 10'h000;
    wr(IOB + 32'h08, 32'hFFFF_FFFF, 4'hF);
    wr(IOB + 32'h14, 32'h0, 4'hF);
    cyc();

    // timer match with reload
    wr(IOB + 32'h10, 32'd5, 4'hF);
    wr(IOB + 32'h0C, 32'd0, 4'hF);
    wr(IOB + 32'h14, 32'h7, 4'hF);
    rd_chk(IOB + 32'h0C, 32'd0, "tmr_c0");
    for (int k = 1; k <= 5; k++) begin
      cyc();
      rd_chk(IOB + 32'h0C, 32'(k), "tmr_ck");
    end
    rd_chk(IOB + 32'h18, 32'h0, "tmr_st0");
    cyc();
    rd_chk(IOB + 32'h0C, 32'd0, "tmr_reload");
    rd_chk(IOB + 32'h18, 32'h1, "tmr_st1");
    check("tmr_irq_lag", 32'(irq), 32'h0);
    cyc();
    check("tmr_irq", 32'(irq), 32'h1);
    wr(IOB + 32'h18, 32'h1, 4'hF);
    rd_chk(IOB + 32'h18, 32'h0, "tmr_w1c");
    check("tmr_irq_hold", 32'(irq), 32'h1);
    cyc();
    check("tmr_irq_drop", 32'(irq), 32'h0);
    wr(IOB + 32'h14, 32'h0, 4'hF);

    // wrap
    wr(IOB + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(IOB + 32'h14, 32'h1, 4'hF);
    wr(IOB + 32'h0C, 32'hFFFF_FFFE, 4'hF);
    rd_chk(IOB + 32'h0C, 32'hFFFF_FFFE, "wrap_ld");
    cyc();
    rd_chk(IOB + 32'h0C, 32'hFFFF_FFFF, "wrap_ff");
    rd_chk(IOB + 32'h18, 32'h0, "wrap_st0");
    cyc();
    rd_chk(IOB + 32'h0C, 32'h0, "wrap_0");
    rd_chk(IOB + 32'h18, 32'h1, "wrap_st1");
    cyc();
    rd_chk(IOB + 32'h0C, 32'h1, "wrap_1");
    wr(IOB + 32'h18, 32'h1, 4'hF);
    rd_chk(IOB + 32'h18, 32'h0, "wrap_clr");
    wr(IOB + 32'h14, 32'h0, 4'hF);

    // illegal writes
    wr(IOB + 32'h04, 32'h0AA, 4'hF);
    check("led_ok", 32'(leds), 32'h0AA);
    check("led_ok_bad", 32'(bad_wr), 32'h0);
    wr(IOB + 32'h04, 32'h3FF, 4'b0011);
    check("led_be_bad", 32'(bad_wr), 32'h1);
    check("led_be_keep", 32'(leds), 32'h0AA);
    cyc();
    check("bad_pulse", 32'(bad_wr), 32'h0);
    wr(IOB, 32'h3FF, 4'hF);
    check("sw_wr_bad", 32'(bad_wr), 32'h1);
    rd_chk(IOB, 32'h0, "sw_keep");
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    check("unmap_bad", 32'(bad_wr), 32'h1);
    rd_chk(32'h8000_0000, 32'h0, "unmap_rd");
    wr(IOB + 32'h1C, 32'h1, 4'hF);
    check("rsvd_bad", 32'(bad_wr), 32'h1);
    rd_chk(IOB + 32'h1C, 32'h0, "rsvd_rd");
    cyc();

    // random traffic
    repeat (600) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, DW * 4 - 1));
        4, 5, 6, 7: a = IOB | 32'($urandom_range(0, 31));
        default: a = $urandom_range(0, 1) ?
                     32'h8000_0000 + 32'($urandom_range(0, 255)) :
                     32'h0000_1000 + 32'($urandom_range(0, 255));
      endcase
      we = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wd = $urandom_range(0, 1) ? $urandom
                                : 32'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) switches = 10'($urandom);
      cyc();
    end
    we = 1'b0;
    switches = 10'h000;
    repeat (3) cyc();
    wr(IOB + 32'h14, 32'h0, 4'hF);
    wr(IOB + 32'h08, 32'hFFFF_FFFF, 4'hF);

    // async reset mid-count
    wr(32'h20, 32'h1234_5678, 4'hF);
    wr(IOB + 32'h04, 32'h3FF, 4'hF);
    switches = 10'h001;
    repeat (3) cyc();
    wr(IOB + 32'h14, 32'h9, 4'hF);
    cyc();
    check("pre_rst_irq", 32'(irq), 32'h1);
    check("pre_rst_leds", 32'(leds), 32'h3FF);
    reset_n = 1'b0;
    #1;
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    rd_chk(IOB + 32'h0C, 32'h0, "arst_count");
    repeat (2) cyc();
    reset_n = 1'b1;
    rd_chk(32'h20, 32'h1234_5678, "ram_keep");
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Parametrised successor to the single-cycle data memory. Provides a word-addressed RAM with byte-lane writes and a bank of memory-mapped peripheral registers.
- Peripherals: synchronised switches with sticky edge flags, LEDs, a 32-bit timer with compare, and an interrupt status register.
- Sits on the processor data port. The read path stays combinational, so the single-cycle core still works. Peripheral state is fully sequential.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, 16..4096.
- NUM_SW, 10, switch input width (1..32).
- NUM_LED, 10, LED output width (1..32).
- IO_BASE, 32'hC000_0000, base address of the peripheral window.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  write strobe, sampled on rising clk.
- be  in  4  byte enables; be[i] writes wd[8i+7:8i].
- a  in  32  byte address.
- wd  in  32  write data.
- rd  out  32  read data (combinational).
- switches  in  NUM_SW  asynchronous switch inputs.
- leds  out  NUM_LED  LED register.
- irq  out  1  level interrupt: OR of enabled pending bits.
- bad_wr  out  1  one-cycle pulse, asserted the cycle after an illegal write.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: leds=0, sw_sync=0, sw_edge=0, count=0, cmp=32'hFFFF_FFFF, ctrl=0, irq_status=0, irq=0, bad_wr=0. RAM contents are not reset.
- Address decode:
  - RAM when a < DEPTH_WORDS*4; index is a[log2(DEPTH_WORDS)+1:2].
  - IO when a[31:5] == IO_BASE[31:5].
  - Anything else is unmapped. a[1:0] is ignored everywhere.
- IO register map (offset from IO_BASE):
  - 0x00 SW (RO): {zeros, sw_sync}. Two-flop synchroniser, so a switch change is visible 2 cycles later.
  - 0x04 LED (RW): leds.
  - 0x08 SW_EDGE (R/W1C): a bit sets on a 0->1 transition of sw_sync. Writing 1 clears the bit.
  - 0x0C COUNT (RW): timer count. A write loads the value.
  - 0x10 CMP (RW): compare value.
  - 0x14 CTRL (RW): bit0 timer enable, bit1 auto-reload-to-0 on match, bit2 timer irq enable, bit3 switch irq enable.
  - 0x18 IRQ_STATUS (R/W1C): bit0 timer match, bit1 any SW_EDGE bit nonzero (read-only mirror, not clearable here).
  - 0x1C: reads 0; a write is illegal.
- Read data:
  - Unmapped addresses and unused upper bits read 0.
  - Reads have no side effects.
- RAM write: on a rising clk with we=1, each byte lane with be[i]=1 is written.
- IO writes:
  - Legal only when be=4'b1111.
  - Any other be leaves the register unchanged and pulses bad_wr.
  - A write to SW, to 0x1C, or to an unmapped address also pulses bad_wr.
  - bad_wr is a registered pulse, high for exactly the one cycle after the offending edge.
- Timer:
  - When ctrl[0]=1, count increments by 1 each cycle and wraps from 32'hFFFF_FFFF to 0.
  - Match means count==cmp while enabled. Match sets irq_status[0].
  - With ctrl[1]=1, the next count after a match is 0 instead of cmp+1.
  - A CPU write to COUNT takes priority over increment and reload. No match is evaluated in that cycle.
- Simultaneous set and clear: in the same cycle, the hardware set wins for both SW_EDGE and IRQ_STATUS[0].
- irq = (irq_status[0] & ctrl[2]) | (|sw_edge & ctrl[3]). It is registered, so it lags status by one cycle.
- Reset asserted mid-operation clears all registers immediately, independent of clk.

Decomposition:
- Shared package dmem_mmio_pkg holds:
  - register offset constants (OFS_SW..OFS_RSVD);
  - CTRL bit indices (CTRL_EN, CTRL_RELOAD, CTRL_TIE, CTRL_SIE);
  - IRQ_STATUS bit indices.
- Sub-module mmio_timer holds count, cmp, ctrl-driven increment, reload and match. It outputs a match pulse and count/cmp readback.

Test Plan:
- Byte lanes: write 32'hAABBCCDD to 0x10 with be=4'hF, then write 32'h11223344 with be=4'b0101 -> read 0x10 = 32'hAA22CC44.
- Switch path: switches 10'h000 -> 10'h005 at cycle N:
  - SW reads 10'h005 from cycle N+2;
  - SW_EDGE reads 32'h5;
  - with ctrl[3]=1, irq=1;
  - writing 32'h1 to SW_EDGE leaves 32'h4 and irq stays 1.
- Timer: CMP=5, CTRL=32'h7, COUNT=0:
  - irq_status[0] is set when count=5 and count then restarts at 0;
  - irq rises one cycle after the status bit;
  - W1C of IRQ_STATUS clears the bit and irq drops the following cycle.
- Wrap: COUNT=32'hFFFF_FFFE, CTRL=1 -> count reads FFFF_FFFF, then 0, then 1; no match with cmp at its reset value except at FFFF_FFFF.
- Illegal writes each give a one-cycle bad_wr pulse with the target unchanged:
  - LED write with be=4'b0011;
  - write to IO_BASE+0x00;
  - write to 32'h8000_0000.
- Async reset: assert reset_n=0 mid-count with leds=10'h3FF -> leds, count and irq are 0 immediately, before the next clk edge; RAM data written before reset is still readable afterwards.
